// File: rtl/led_pio_write_arbiter.sv
// led_pio_write_arbiter
//
// Shares the single 8-bit LED PIO output register (Avalon-MM slave, word
// address 0) between NUM_REQ requesters. A shadow copy of the LED register is
// kept here; each granted request is merged into it under its bit mask and
// written to the PIO as one Avalon write. The winner then gets a one-cycle ack.
//
// Optional feature: define LED_PIO_READBACK_EN to add a one-cycle readback of
// the PIO after every write. A mismatch against the shadow sets the sticky err.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   req            per-requester request level
//   req_data       requester i LED value in bits [8i+7:8i]
//   req_mask       requester i bit-enable (1 = bit is updated)
//   ack            one-cycle grant-complete pulse, one-hot
//   avm_address    PIO word address, constant 0
//   avm_chipselect PIO chipselect
//   avm_write_n    PIO write strobe, active-low
//   avm_writedata  {24'b0, merged LED value}
//   avm_readdata   PIO readdata (only used with LED_PIO_READBACK_EN)
//   shadow         LED value as last written by this block
//   busy           high whenever the FSM is not idle
//   err            sticky readback mismatch (0 without LED_PIO_READBACK_EN)

module led_pio_write_arbiter #(
  parameter int         NUM_REQ    = 3,
  parameter logic [7:0] RESET_LEDS = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [8*NUM_REQ-1:0] req_mask,
  output logic [NUM_REQ-1:0]   ack,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  output logic [7:0]           shadow,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   winner_reg, winner_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [7:0]         shadow_reg, shadow_next;
  logic [7:0]         writedata_reg, writedata_next;
  logic               cs_reg, cs_next;
  logic               write_n_reg, write_n_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;

  // Per-requester views of the flat data/mask buses.
  logic [7:0] data_arr [NUM_REQ];
  logic [7:0] mask_arr [NUM_REQ];

  // cand_idx[k] is the requester examined k-th in round-robin order, i.e.
  // (rr_ptr + k + 1) mod NUM_REQ. The sum never reaches 2*NUM_REQ, so one
  // conditional subtraction is a full modulo.
  logic [IDX_W:0]   cand_sum [NUM_REQ];
  logic [IDX_W-1:0] cand_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi] = req_data[8*gi +: 8];
      assign mask_arr[gi] = req_mask[8*gi +: 8];
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                          : cand_sum[gi][IDX_W-1:0];
    end
  endgenerate

  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic [7:0]       merged;

  // Scan from the lowest-priority candidate upwards so the first high
  // request in round-robin order is the one left in pick.
  always_comb begin
    any_req = |req;
    pick    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        pick = cand_idx[k];
      end
    end
    merged = (shadow_reg & ~mask_arr[pick]) | (data_arr[pick] & mask_arr[pick]);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      winner_reg    <= '0;
      rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
      shadow_reg    <= RESET_LEDS;
      writedata_reg <= 8'h00;
      cs_reg        <= 1'b0;
      write_n_reg   <= 1'b1;
      ack_reg       <= '0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      winner_reg    <= winner_next;
      rr_ptr_reg    <= rr_ptr_next;
      shadow_reg    <= shadow_next;
      writedata_reg <= writedata_next;
      cs_reg        <= cs_next;
      write_n_reg   <= write_n_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (any_req) state_next = WRITE;
`ifdef LED_PIO_READBACK_EN
      WRITE: state_next = READ;
`else
      WRITE: state_next = ACK;
`endif
      READ:  state_next = ACK;
      ACK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs. Each value is computed one cycle
  // ahead so that it appears on the pins in the state it belongs to.
  always_comb begin
    winner_next    = winner_reg;
    rr_ptr_next    = rr_ptr_reg;
    shadow_next    = shadow_reg;
    writedata_next = writedata_reg;
    cs_next        = 1'b0;
    write_n_next   = 1'b1;
    ack_next       = '0;
    busy_next      = (state_next != IDLE);
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          winner_next    = pick;
          writedata_next = merged;
          cs_next        = 1'b1;
          write_n_next   = 1'b0;
        end
      end
      WRITE: begin
        shadow_next = writedata_reg;
        rr_ptr_next = winner_reg;
`ifdef LED_PIO_READBACK_EN
        cs_next     = 1'b1;  // read cycle: chipselect with write_n high
`else
        ack_next[winner_reg] = 1'b1;
`endif
      end
      READ: begin
        // shadow already holds the value written in WRITE.
        if (avm_readdata[7:0] != shadow_reg) begin
          err_next = 1'b1;
        end
        ack_next[winner_reg] = 1'b1;
      end
      default: ;
    endcase
  end

  assign ack            = ack_reg;
  assign avm_address    = 2'b00;
  assign avm_chipselect = cs_reg;
  assign avm_write_n    = write_n_reg;
  assign avm_writedata  = {24'h000000, writedata_reg};
  assign shadow         = shadow_reg;
  assign busy           = busy_reg;

`ifdef LED_PIO_READBACK_EN
  assign err = err_reg;
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:8];
`else
  // Without readback nothing can set err; the register stays at reset value.
  assign err = 1'b0;
  logic unused_readdata;
  assign unused_readdata = ^{avm_readdata, err_reg};
`endif

endmodule
